param_serial_branch_alu: RTL and testbench
==========================================

# param_serial_branch_alu

Nibble-serial address and branch-compare ALU. It is the far end of the PC computation unit's bit-serial interface. It consumes the PC (or register) nibble stream and the immediate/rs2 nibble stream, least-significant nibble first, and returns one sum nibble per accepted pair for the address deserializing register. After the last nibble it reports a registered branch-taken decision used to steer the PC mux.

## Interface
Parameters:
- P_NBITS, 4, bits per serial beat.
- C_N_OFF, 8, beats per 32-bit word (32/P_NBITS).
- C_OFFBITS, 3, width of the beat index.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start_Xhl  in  1  begin a new operation and latch op_Xhl.
- op_Xhl  in  3  0 ADD, 1 SUB, 2 BEQ, 3 BNE, 4 BLT, 5 BGE, 6 BLTU, 7 BGEU.
- nib_valid_Xhl  in  1  a_nib/b_nib carry a valid beat this cycle.
- a_nib_Xhl  in  P_NBITS  operand A beat.
- b_nib_Xhl  in  P_NBITS  operand B beat.
- sum_nib_Xhl  out  P_NBITS  result beat; combinational; 0 when no beat is accepted.
- sum_valid_Xhl  out  1  a beat is accepted this cycle.
- nib_idx_Xhl  out  C_OFFBITS  index of the next beat expected.
- busy_Xhl  out  1  FSM is in RUN.
- done_Xhl  out  1  one-cycle pulse after the final beat.
- taken_Xhl  out  1  branch decision; held until the next start.

## Operation
- FSM states: IDLE and RUN.
  - IDLE to RUN on start_Xhl.
  - RUN to IDLE at the edge that accepts beat C_N_OFF-1.
- start_Xhl actions:
  - Latches op.
  - Clears nib_idx to 0, eq_acc to 1 and taken to 0.
  - Initialises the carry register: 0 for ADD, 1 for all other ops (computes A + ~B + 1).
- No beat is accepted in the start cycle; the first beat is accepted no earlier than the next cycle.
- A beat is accepted when busy_Xhl && nib_valid_Xhl && !start_Xhl.
  - sum_nib = A + B' + carry, where B' = B for ADD and ~B otherwise.
  - At the edge: carry <= carry-out, eq_acc <= eq_acc & (A == B), nib_idx <= nib_idx + 1.
  - nib_idx wraps to 0 after C_N_OFF-1.
- On the final beat, the MSB of each of A, B and sum is captured. The decision at the same edge is:
  - BEQ: eq. BNE: !eq.
  - BLT: (a31 != b31) ? a31 : s31. BGE: the inverse of BLT.
  - BLTU: !carry_out. BGEU: carry_out.
  - ADD/SUB: 0.
- The carry-out of beat 7 is discarded from the sum (32-bit wrap).
- nib_valid low while in RUN is a stall: all state is held and sum_nib is 0.
- start_Xhl while in RUN aborts the current op and restarts. The aborted op produces no done.
- Beats presented in IDLE are ignored.

## Timing
- Reset values: busy 0, done 0, taken 0, nib_idx 0, sum_valid 0, sum_nib 0, carry 0, eq_acc 1.
- Reset is asynchronous: all of the above take effect immediately, including in the middle of an operation.
- sum_nib/sum_valid have zero latency from the inputs.
- done is asserted for exactly one cycle, in the cycle after beat 7 is accepted. taken is valid in that same cycle.
- Minimum operation length: start cycle + 8 beats + done = 10 cycles.
- done and a new start may coincide: the start is honoured and taken is cleared the following edge.

## Structure
- Shared include param-SerialAluOps.v holds:
  - the op encodings;
  - P_NBITS, C_N_OFF and C_OFFBITS;
  - the FSM state encodings.
- Sub-module param_SerialAddSlice: combinational P_NBITS adder with carry-in, carry-out and optional B inversion. It is instantiated once.
- The top level holds the FSM, the beat counter, the carry/eq registers, MSB capture and decision logic. Target size: about 200 lines of RTL.

## Test plan
- ADD, A=0x00080000, B=0x00000010, start then 8 back-to-back beats -> sum beats 0,1,0,0,8,0,0,0; done 9 cycles after start; taken 0.
- ADD 0xFFFFFFFF + 0x00000001 -> all 8 sum beats 0 (wrap); SUB 0x10 - 0x1 -> beats F,0,0,0,0,0,0,0.
- BEQ 0x12345678 vs 0x12345678 -> taken 1; BNE same operands -> taken 0; BEQ vs 0x92345678 (differs only in beat 7) -> taken 0.
- Signed vs unsigned, A=0xFFFFFFFF, B=0x00000001 -> BLT taken 1, BGE 0, BLTU 0, BGEU 1.
- Stall: nib_valid low for 3 cycles after beat 3 -> nib_idx holds at 4, sum_nib is 0 during the stall, result is unchanged, done arrives 3 cycles late.
- Abort and reset: start at nib_idx 5 -> idx 0, carry re-initialised, no done for the first op. reset asserted mid-RUN -> busy, done and taken are 0 before the next clock edge.

Source files
------------

// File: rtl/param_serial_branch_alu_pkg.sv
// Shared widths, op encodings, FSM states and branch-decision helper for the
// nibble-serial address/branch ALU.
package param_serial_branch_alu_pkg;

  localparam int unsigned P_NBITS   = 4;
  localparam int unsigned C_N_OFF   = 8;
  localparam int unsigned C_OFFBITS = 3;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_BEQ  = 3'd2,
    OP_BNE  = 3'd3,
    OP_BLT  = 3'd4,
    OP_BGE  = 3'd5,
    OP_BLTU = 3'd6,
    OP_BGEU = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Decision from the running equality and the final beat's MSBs/carry-out.
  function automatic logic branch_decide(input op_e op, input logic eq,
                                         input logic a_msb, input logic b_msb,
                                         input logic s_msb, input logic cout);
    logic lt;
    logic res;
    lt  = (a_msb != b_msb) ? a_msb : s_msb;
    res = 1'b0;
    case (op)
      OP_BEQ:  res = eq;
      OP_BNE:  res = !eq;
      OP_BLT:  res = lt;
      OP_BGE:  res = !lt;
      OP_BLTU: res = !cout;
      OP_BGEU: res = cout;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/param_serial_branch_alu_if.sv
// Beat-stream interface between the PC computation unit (master) and the
// serial ALU (slave).
interface param_serial_branch_alu_if;
  import param_serial_branch_alu_pkg::*;

  logic                 start_Xhl;
  logic [2:0]           op_Xhl;
  logic                 nib_valid_Xhl;
  logic [P_NBITS-1:0]   a_nib_Xhl;
  logic [P_NBITS-1:0]   b_nib_Xhl;
  logic [P_NBITS-1:0]   sum_nib_Xhl;
  logic                 sum_valid_Xhl;
  logic [C_OFFBITS-1:0] nib_idx_Xhl;
  logic                 busy_Xhl;
  logic                 done_Xhl;
  logic                 taken_Xhl;

  modport master (
    output start_Xhl, op_Xhl, nib_valid_Xhl, a_nib_Xhl, b_nib_Xhl,
    input  sum_nib_Xhl, sum_valid_Xhl, nib_idx_Xhl, busy_Xhl, done_Xhl, taken_Xhl
  );

  modport slave (
    input  start_Xhl, op_Xhl, nib_valid_Xhl, a_nib_Xhl, b_nib_Xhl,
    output sum_nib_Xhl, sum_valid_Xhl, nib_idx_Xhl, busy_Xhl, done_Xhl, taken_Xhl
  );

endinterface

// File: rtl/param_serial_branch_alu_add_slice.sv
// One-beat adder: sum = a + (inv_b ? ~b : b) + cin, with carry-out.
module param_serial_branch_alu_add_slice
  import param_serial_branch_alu_pkg::*;
(
  input  logic [P_NBITS-1:0] i_a,
  input  logic [P_NBITS-1:0] i_b,
  input  logic               i_cin,
  input  logic               i_inv_b,
  output logic [P_NBITS-1:0] o_sum,
  output logic               o_cout
);

  logic [P_NBITS-1:0] w_b;

  assign w_b = i_inv_b ? ~i_b : i_b;
  assign {o_cout, o_sum} = (P_NBITS+1)'(i_a) + (P_NBITS+1)'(w_b) + (P_NBITS+1)'(i_cin);

endmodule

// File: rtl/param_serial_branch_alu.sv
// Nibble-serial address / branch-compare ALU: LS beat first, one sum beat per
// accepted pair, registered branch decision after the final beat.
module param_serial_branch_alu
  import param_serial_branch_alu_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  param_serial_branch_alu_if.slave   bus
);

  localparam logic [C_OFFBITS-1:0] C_LAST_IDX = C_OFFBITS'(C_N_OFF - 1);

  state_e               r_state;
  state_e               w_next_state;
  op_e                  r_op;
  logic                 r_carry;
  logic                 r_eq;
  logic [C_OFFBITS-1:0] r_nib_idx;
  logic                 r_done;
  logic                 r_taken;

  logic                 w_accept;
  logic                 w_last;
  logic                 w_beat_eq;
  logic [P_NBITS-1:0]   w_sum;
  logic                 w_cout;

  assign w_accept  = (r_state == ST_RUN) && bus.nib_valid_Xhl && !bus.start_Xhl;
  assign w_last    = w_accept && (r_nib_idx == C_LAST_IDX);
  assign w_beat_eq = (bus.a_nib_Xhl == bus.b_nib_Xhl);

  param_serial_branch_alu_add_slice u_add_slice (
    .i_a     (bus.a_nib_Xhl),
    .i_b     (bus.b_nib_Xhl),
    .i_cin   (r_carry),
    .i_inv_b (r_op != OP_ADD),
    .o_sum   (w_sum),
    .o_cout  (w_cout)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state: start always wins (new op or abort/restart)
  always_comb begin
    w_next_state = r_state;
    if (bus.start_Xhl)  w_next_state = ST_RUN;
    else if (w_last)    w_next_state = ST_IDLE;
  end

  // Datapath registers: op, carry chain, equality accumulator, beat index, result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op      <= OP_ADD;
      r_carry   <= 1'b0;
      r_eq      <= 1'b1;
      r_nib_idx <= '0;
      r_done    <= 1'b0;
      r_taken   <= 1'b0;
    end else begin
      r_done <= w_last;
      if (bus.start_Xhl) begin
        r_op      <= op_e'(bus.op_Xhl);
        r_carry   <= (op_e'(bus.op_Xhl) != OP_ADD);
        r_eq      <= 1'b1;
        r_nib_idx <= '0;
        r_taken   <= 1'b0;
      end else if (w_accept) begin
        r_carry   <= w_cout;
        r_eq      <= r_eq & w_beat_eq;
        r_nib_idx <= w_last ? '0 : r_nib_idx + C_OFFBITS'(1);
        if (w_last) begin
          r_taken <= branch_decide(r_op, r_eq & w_beat_eq,
                                   bus.a_nib_Xhl[P_NBITS-1], bus.b_nib_Xhl[P_NBITS-1],
                                   w_sum[P_NBITS-1], w_cout);
        end
      end
    end
  end

  // Outputs; the sum beat is forced to zero when nothing is accepted
  always_comb begin
    bus.sum_nib_Xhl   = '0;
    bus.sum_valid_Xhl = w_accept;
    bus.nib_idx_Xhl   = r_nib_idx;
    bus.busy_Xhl      = (r_state == ST_RUN);
    bus.done_Xhl      = r_done;
    bus.taken_Xhl     = r_taken;
    if (w_accept) bus.sum_nib_Xhl = w_sum;
  end

endmodule

// File: tb/tb_param_serial_branch_alu.sv
// Directed self-checking bench for param_serial_branch_alu.
module tb_param_serial_branch_alu;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  param_serial_branch_alu_if bus ();

  param_serial_branch_alu u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] op);
    @(negedge clk);
    bus.start_Xhl     = 1'b1;
    bus.op_Xhl        = op;
    bus.nib_valid_Xhl = 1'b0;
  endtask

  task automatic beat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] exp_sum,
                      input int idx, input string tag);
    @(negedge clk);
    bus.start_Xhl     = 1'b0;
    bus.nib_valid_Xhl = 1'b1;
    bus.a_nib_Xhl     = a;
    bus.b_nib_Xhl     = b;
    #1;
    check({tag, " sum"},   32'(bus.sum_nib_Xhl), 32'(exp_sum));
    check({tag, " valid"}, 32'(bus.sum_valid_Xhl), 32'd1);
    check({tag, " idx"},   32'(bus.nib_idx_Xhl), 32'(idx));
    check({tag, " busy"},  32'(bus.busy_Xhl), 32'd1);
    check({tag, " nodone"}, 32'(bus.done_Xhl), 32'd0);
  endtask

  task automatic stall_cycle(input int idx, input string tag);
    @(negedge clk);
    bus.nib_valid_Xhl = 1'b0;
    bus.a_nib_Xhl     = 4'h7;
    bus.b_nib_Xhl     = 4'h3;
    #1;
    check({tag, " stall sum"},   32'(bus.sum_nib_Xhl), 32'd0);
    check({tag, " stall valid"}, 32'(bus.sum_valid_Xhl), 32'd0);
    check({tag, " stall idx"},   32'(bus.nib_idx_Xhl), 32'(idx));
    check({tag, " stall done"},  32'(bus.done_Xhl), 32'd0);
  endtask

  task automatic finish_op(input logic exp_taken, input string tag);
    @(negedge clk);
    bus.nib_valid_Xhl = 1'b0;
    bus.start_Xhl     = 1'b0;
    #1;
    check({tag, " done"},  32'(bus.done_Xhl), 32'd1);
    check({tag, " taken"}, 32'(bus.taken_Xhl), 32'(exp_taken));
    check({tag, " idle"},  32'(bus.busy_Xhl), 32'd0);
    @(negedge clk);
    #1;
    check({tag, " done pulse"}, 32'(bus.done_Xhl), 32'd0);
    check({tag, " taken hold"}, 32'(bus.taken_Xhl), 32'(exp_taken));
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_sum, input logic exp_taken,
                        input int stall_at, input string tag);
    start_op(op);
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at)
        for (int s = 0; s < 3; s++) stall_cycle(i, tag);
      beat(a[4*i +: 4], b[4*i +: 4], exp_sum[4*i +: 4], i, tag);
    end
    finish_op(exp_taken, tag);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.start_Xhl     = 1'b0;
    bus.op_Xhl        = 3'd0;
    bus.nib_valid_Xhl = 1'b0;
    bus.a_nib_Xhl     = '0;
    bus.b_nib_Xhl     = '0;
    #1;
    check("rst busy",  32'(bus.busy_Xhl), 32'd0);
    check("rst done",  32'(bus.done_Xhl), 32'd0);
    check("rst taken", 32'(bus.taken_Xhl), 32'd0);
    check("rst idx",   32'(bus.nib_idx_Xhl), 32'd0);
    check("rst valid", 32'(bus.sum_valid_Xhl), 32'd0);
    check("rst sum",   32'(bus.sum_nib_Xhl), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Beats in IDLE are ignored
    @(negedge clk);
    bus.nib_valid_Xhl = 1'b1;
    bus.a_nib_Xhl     = 4'h5;
    bus.b_nib_Xhl     = 4'h6;
    #1;
    check("idle valid", 32'(bus.sum_valid_Xhl), 32'd0);
    check("idle sum",   32'(bus.sum_nib_Xhl), 32'd0);
    @(negedge clk);
    #1;
    check("idle idx",   32'(bus.nib_idx_Xhl), 32'd0);
    check("idle busy",  32'(bus.busy_Xhl), 32'd0);

    run_op(3'd0, 32'h0008_0000, 32'h0000_0010, 32'h0008_0010, 1'b0, -1, "add");
    run_op(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, -1, "add wrap");
    run_op(3'd1, 32'h0000_0010, 32'h0000_0001, 32'h0000_000F, 1'b0, -1, "sub");
    run_op(3'd2, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1, -1, "beq eq");
    run_op(3'd3, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, -1, "bne eq");
    run_op(3'd2, 32'h1234_5678, 32'h9234_5678, 32'h8000_0000, 1'b0, -1, "beq msb");
    run_op(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, -1, "blt");
    run_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, -1, "bge");
    run_op(3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, -1, "bltu");
    run_op(3'd7, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, -1, "bgeu");
    run_op(3'd0, 32'h0008_0000, 32'h0000_0010, 32'h0008_0010, 1'b0, 4, "add stall");

    // Abort: SUB 0-1 for 5 beats leaves carry 0; restart SUB 0x10-1 needs carry 1 again
    start_op(3'd1);
    for (int i = 0; i < 5; i++) beat(4'h0, (i == 0) ? 4'h1 : 4'h0, 4'hF, i, "abort1");
    @(negedge clk);
    bus.start_Xhl     = 1'b1;
    bus.op_Xhl        = 3'd1;
    bus.nib_valid_Xhl = 1'b1;
    #1;
    check("abort start valid", 32'(bus.sum_valid_Xhl), 32'd0);
    for (int i = 0; i < 8; i++)
      beat((i == 1) ? 4'h1 : 4'h0, (i == 0) ? 4'h1 : 4'h0, (i == 0) ? 4'hF : 4'h0, i, "abort2");
    finish_op(1'b0, "abort2");

    // done and a new start in the same cycle
    start_op(3'd2);
    for (int i = 0; i < 8; i++) beat(4'hA, 4'hA, 4'h0, i, "coinc beq");
    @(negedge clk);
    bus.nib_valid_Xhl = 1'b0;
    bus.start_Xhl     = 1'b1;
    bus.op_Xhl        = 3'd0;
    #1;
    check("coinc done",  32'(bus.done_Xhl), 32'd1);
    check("coinc taken", 32'(bus.taken_Xhl), 32'd1);
    @(negedge clk);
    bus.start_Xhl = 1'b0;
    #1;
    check("coinc taken clr", 32'(bus.taken_Xhl), 32'd0);
    check("coinc busy",      32'(bus.busy_Xhl), 32'd1);
    check("coinc done clr",  32'(bus.done_Xhl), 32'd0);
    for (int i = 0; i < 8; i++) beat(4'h3, 4'h4, 4'h7, i, "coinc add");
    finish_op(1'b0, "coinc add");

    // Asynchronous reset in the middle of RUN
    start_op(3'd0);
    for (int i = 0; i < 3; i++) beat(4'h1, 4'h1, 4'h2, i, "rst mid");
    @(negedge clk);
    bus.a_nib_Xhl = 4'h1;
    bus.b_nib_Xhl = 4'h1;
    #1;
    reset = 1'b1;
    #1;
    check("rst mid busy",  32'(bus.busy_Xhl), 32'd0);
    check("rst mid valid", 32'(bus.sum_valid_Xhl), 32'd0);
    check("rst mid idx",   32'(bus.nib_idx_Xhl), 32'd0);
    check("rst mid done",  32'(bus.done_Xhl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.nib_valid_Xhl = 1'b0;

    // Asynchronous reset while done/taken are high
    start_op(3'd2);
    for (int i = 0; i < 8; i++) beat(4'hC, 4'hC, 4'h0, i, "rst done");
    @(negedge clk);
    bus.nib_valid_Xhl = 1'b0;
    #1;
    check("rst done pre",  32'(bus.done_Xhl), 32'd1);
    check("rst taken pre", 32'(bus.taken_Xhl), 32'd1);
    reset = 1'b1;
    #1;
    check("rst done post",  32'(bus.done_Xhl), 32'd0);
    check("rst taken post", 32'(bus.taken_Xhl), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
